// File: rtl/thermal_pkg.sv
// Shared encodings and widths for the room thermal plant model.
// Pure package; no logic state, no timing.
package thermal_pkg;

   localparam int TEMP_W  = 5;
   localparam int ARITH_W = TEMP_W + 1;

   typedef enum logic [1:0] {
      MODE_DRIFT = 2'd0,
      MODE_HEAT  = 2'd1,
      MODE_COOL  = 2'd2,
      MODE_FAULT = 2'd3
   } mode_t;

   // Headroom bit keeps +1 at the top of range visible to the clamp.
   function automatic logic [TEMP_W-1:0] clamp_temp(
      input logic [ARITH_W-1:0] v,
      input logic [ARITH_W-1:0] lo,
      input logic [ARITH_W-1:0] hi
   );
      logic [ARITH_W-1:0] r;
      r = v;
      if (v < lo) r = lo;
      if (v > hi) r = hi;
      return r[TEMP_W-1:0];
   endfunction

endpackage

// File: rtl/room_thermal_model_step_prescaler.sv
// Free-running step divider: tick is high on every STEP_CYCLES-th edge after rst/clr.
// Latency: tick decoded from the count register; clr restarts the period on the next edge.
module step_prescaler #(
   parameter int STEP_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CNT_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign tick = (count_q == LAST);

   always_comb begin
      count_d = count_q + CNT_W'(1);
      if (clr || tick) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/room_thermal_model.sv
// Room temperature plant: registered mode FSM, saturating once-per-step update, sticky fault.
// Latency 1 cycle input->mode, no backpressure; LOAD_PORT_EN adds a direct temperature load port.
module room_thermal_model
   import thermal_pkg::*;
#(
   parameter int STEP_CYCLES = 4,
   parameter int INIT_TEMP   = 18,
   parameter int AMBIENT     = 20,
   parameter int T_MIN       = 0,
   parameter int T_MAX       = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              heating,
   input  logic              cooling,
`ifdef LOAD_PORT_EN
   input  logic              load_en,
   input  logic [TEMP_W-1:0] load_temp,
`endif
   output logic [TEMP_W-1:0] temperature,
   output logic [1:0]        mode,
   output logic              step,
   output logic              fault
);

   localparam logic [ARITH_W-1:0] T_MIN_W   = ARITH_W'(T_MIN);
   localparam logic [ARITH_W-1:0] T_MAX_W   = ARITH_W'(T_MAX);
   localparam logic [ARITH_W-1:0] AMBIENT_W = ARITH_W'(AMBIENT);
   localparam logic [TEMP_W-1:0]  INIT_T    = TEMP_W'(INIT_TEMP);

   mode_t              mode_q, mode_d;
   logic [TEMP_W-1:0]  temp_q, temp_d;
   logic               step_q, step_d;
   logic               fault_q, fault_d;

   logic               tick;
   logic               presc_clr;
   logic [ARITH_W-1:0] temp_w;
   logic [ARITH_W-1:0] next_w;
   logic [TEMP_W-1:0]  stepped;

   step_prescaler #(
      .STEP_CYCLES (STEP_CYCLES)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (presc_clr),
      .tick (tick)
   );

   // FAULT is absorbing: once entered only rst leaves it.
   always_comb begin
      if (mode_q == MODE_FAULT || (heating && cooling)) begin
         mode_d = MODE_FAULT;
      end else if (heating) begin
         mode_d = MODE_HEAT;
      end else if (cooling) begin
         mode_d = MODE_COOL;
      end else begin
         mode_d = MODE_DRIFT;
      end
      fault_d = (mode_d == MODE_FAULT);
   end

   always_comb begin
      temp_w = {1'b0, temp_q};
      next_w = temp_w;
      unique case (mode_q)
         MODE_HEAT: next_w = temp_w + ARITH_W'(1);
         MODE_COOL: next_w = (temp_w > T_MIN_W) ? (temp_w - ARITH_W'(1)) : T_MIN_W;
         MODE_DRIFT: begin
            if (temp_w < AMBIENT_W) begin
               next_w = temp_w + ARITH_W'(1);
            end else if (temp_w > AMBIENT_W) begin
               next_w = temp_w - ARITH_W'(1);
            end else begin
               next_w = temp_w;
            end
         end
         MODE_FAULT: next_w = temp_w;
      endcase
      stepped = clamp_temp(next_w, T_MIN_W, T_MAX_W);
   end

   // A load replaces the step result and restarts the step period.
   always_comb begin
      temp_d    = tick ? stepped : temp_q;
      step_d    = tick;
      presc_clr = 1'b0;
`ifdef LOAD_PORT_EN
      if (load_en) begin
         temp_d    = clamp_temp({1'b0, load_temp}, T_MIN_W, T_MAX_W);
         step_d    = 1'b0;
         presc_clr = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= MODE_DRIFT;
         temp_q  <= INIT_T;
         step_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         temp_q  <= temp_d;
         step_q  <= step_d;
         fault_q <= fault_d;
      end
   end

   assign temperature = temp_q;
   assign mode        = mode_q;
   assign step        = step_q;
   assign fault       = fault_q;

endmodule
